// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the single write port of simple_fifo
// Optional per-requester accept counters are enabled by defining FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush,
  output logic                         fifo_wr,
  output logic [WIDTH-1:0]             fifo_data,
  output logic                         fifo_rst,
  input  logic                         fifo_rd,
  input  logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        accept_cnt
`endif
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          space;
  logic          accept;
  logic          pop;

  // level already counts in-flight writes, so the FIFO can never be written while full
  assign space = rst_n && (level < LVL_MAX) && !flush && !fifo_rst;
  assign pop   = fifo_rd && !fifo_empty;

  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    req_ready = '0;
    grant_idx = ptr;
    accept    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (space && !accept && req_valid[idx]) begin
        accept    = 1'b1;
        grant_idx = idx;
      end
    end
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
      fifo_rst  <= 1'b0;
      level     <= '0;
      ptr       <= PW'(NUM_REQ-1);
    end else if (flush) begin
      fifo_rst <= 1'b1;
      fifo_wr  <= 1'b0;
      level    <= '0;
    end else begin
      fifo_rst <= 1'b0;
      fifo_wr  <= accept;
      if (accept) begin
        fifo_data <= req_data[grant_idx*WIDTH +: WIDTH];
        ptr       <= grant_idx;
      end
      // a pop seen at level 0 is a system error; clamp rather than wrap
      if (accept && !pop) begin
        level <= level + 1'b1;
      end else if (!accept && pop && level != '0) begin
        level <= level - 1'b1;
      end
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
    end else if (flush) begin
      accept_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant_idx == PW'(i) && accept_cnt[i*16 +: 16] != 16'hFFFF) begin
          accept_cnt[i*16 +: 16] <= accept_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a behavioural simple_fifo
module tb_fifo_wr_arbiter;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 32;
  localparam int NUM_REQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        flush;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic        fifo_rst;
  logic        fifo_rd;
  logic        fifo_empty;
  logic [5:0]  level;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [63:0] accept_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .flush      (flush),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .fifo_rst   (fifo_rst),
    .fifo_rd    (fifo_rd),
    .fifo_empty (fifo_empty),
    .level      (level)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .accept_cnt (accept_cnt)
`endif
  );

  // behavioural simple_fifo: registered empty flag, read ignored when empty
  logic [7:0] fq[$];
  logic       fq_empty = 1'b1;
  logic       force_ne;
  assign fifo_empty = fq_empty && !force_ne;

  always @(posedge clk) begin
    if (!rst_n || fifo_rst) begin
      fq.delete();
      fq_empty <= 1'b1;
    end else begin
      if (fifo_rd && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wr && fq.size() < DEPTH) fq.push_back(fifo_data);
      fq_empty <= (fq.size() == 0);
    end
  end

  logic [7:0] words[4][64];
  int         head[4];
  int         tail[4];
  logic [3:0] en;
  logic [3:0] acc_mask;
  logic [7:0] exp_q[$];
  int         checks;
  int         errors;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic load(input int r, input logic [7:0] w);
    words[r][tail[r]] = w;
    tail[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = en[i] && (head[i] < tail[i]);
      req_data[i*8 +: 8] = (head[i] < tail[i]) ? words[i][head[i]] : 8'h00;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc_mask = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc_mask[i]) head[i]++;
    drive();
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && fifo_wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h expected=none", fifo_data);
        end else begin
          chk("wr_data", fifo_data, exp_q.pop_front());
          chk("wr_not_full", fq.size() < DEPTH, 1);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; flush = 1'b0;
    fifo_rd = 1'b0; force_ne = 1'b0; en = '0; acc_mask = '0;
    checks = 0; errors = 0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
    fork monitor(); join_none

    // reset state, with requests presented
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wr", fifo_wr, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_frst", fifo_rst, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // all four continuously valid, consumer reading every cycle
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 4; i++) begin
        load(i, 8'(i*16 + k));
        exp_q.push_back(8'(i*16 + k));
      end
    en = 4'hF; fifo_rd = 1'b1;
    drive();
    #1;
    for (int n = 0; n < 32; n++) begin
      chk("rr_grant", req_ready, 4'b0001 << (n % 4));
      tick();
      chk("rr_wr", fifo_wr, 1);
      chk("rr_level", level, (n == 0) ? 1 : 2);
    end
    repeat (3) tick();
    chk("rr_drained", level, 0);
    chk("rr_idle_wr", fifo_wr, 0);
    force_ne = 1'b1;
    tick();
    chk("clamp_level", level, 0);
    force_ne = 1'b0; fifo_rd = 1'b0;

    // single requester fills the FIFO, 33rd word is held
    for (int k = 1; k <= 33; k++) load(2, 8'(k));
    for (int k = 1; k <= 32; k++) exp_q.push_back(8'(k));
    en = 4'b0100;
    drive();
    #1;
    chk("s1_first", req_ready, 4'b0100);
    repeat (32) tick();
    chk("s1_level", level, 32);
    chk("s1_ready_full", req_ready, 0);
    repeat (2) tick();
    chk("s1_hold_level", level, 32);
    chk("s1_hold_ready", req_ready, 0);
    chk("s1_hold_wr", fifo_wr, 0);

    // one pop at full permits exactly one grant
    exp_q.push_back(8'h21);
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    chk("bd_level", level, 31);
    chk("bd_ready", req_ready, 4'b0100);
    tick();
    chk("bd_refill", level, 32);
    chk("bd_ready_off", req_ready, 0);
    chk("bd_wr", fifo_wr, 1);
    tick();
    chk("bd_wr_done", fifo_wr, 0);
    fifo_rd = 1'b1;
    repeat (34) tick();
    chk("drain_level", level, 0);
    fifo_rd = 1'b0;

    // simultaneous accept and pop at level 10
    for (int k = 0; k < 15; k++) begin
      load(1, 8'(8'hA0 + k));
      exp_q.push_back(8'(8'hA0 + k));
    end
    en = 4'b0010;
    drive();
    #1;
    repeat (10) tick();
    chk("s4_fill", level, 10);
    fifo_rd = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("s4_level", level, 10);
    end
    fifo_rd = 1'b0;
    tick();
    chk("s4_hold", level, 10);

    // flush at level 17 with requesters valid
    for (int k = 0; k < 7; k++) begin
      load(0, 8'(8'hC0 + k));
      exp_q.push_back(8'(8'hC0 + k));
    end
    en = 4'b0001;
    drive();
    #1;
    repeat (7) tick();
    chk("fl_pre_level", level, 17);
    load(0, 8'hC8); load(0, 8'hC9);
    load(1, 8'hD0); load(1, 8'hD1);
    exp_q.push_back(8'hD0); exp_q.push_back(8'hC8);
    exp_q.push_back(8'hD1); exp_q.push_back(8'hC9);
    en = 4'b0011; flush = 1'b1;
    drive();
    #1;
    chk("fl_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_rst", fifo_rst, 1);
    chk("fl_level", level, 0);
    chk("fl_wr", fifo_wr, 0);
    chk("fl_ready_rst", req_ready, 0);
    tick();
    chk("fl_rst_pulse", fifo_rst, 0);
    for (int n = 0; n < 4; n++) begin
      chk("fl_resume", req_ready, (n % 2 == 0) ? 4'b0010 : 4'b0001);
      tick();
    end
    chk("fl_after_level", level, 4);

    // asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) load(i, 8'(8'hE0 + i));
    exp_q.push_back(8'hE1);
    en = 4'hF;
    drive();
    #1;
    tick();
    tick();
    chk("mr_pre_wr", fifo_wr, 1);
    chk("mr_pre_level", level, 6);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_wr", fifo_wr, 0);
    chk("mr_level", level, 0);
    chk("mr_ready", req_ready, 0);
    chk("mr_frst", fifo_rst, 0);
`ifdef FIFO_WR_ARBITER_STATS_EN
    chk("mr_cnt_lo", accept_cnt[31:0], 0);
    chk("mr_cnt_hi", accept_cnt[63:32], 0);
`endif
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("mr_prio0", req_ready, 4'b0001);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE3);
    tick();
    tick();
    chk("mr_level_after", level, 2);
    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
